// File: rtl/game_pkg.sv
// Shared types and constants for the combo game controller and its symbol-to-combo lookup.
// The default combo table lives here so the lookup and any bench model agree on one source.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FETCH,
        MATCH,
        SCORE,
        RD,
        CMP,
        DONE
    } state_t;

    localparam logic [6:0] BLANK_SYM = 7'h7F;
    localparam logic [6:0] SYM_ONE   = 7'h3F;
    localparam logic [6:0] SYM_TWO   = 7'h3E;
    localparam logic [6:0] SYM_THREE = 7'h36;
    localparam logic [6:0] SYM_SEVEN = 7'h07;

    localparam int LUT_KEY_W   = 2;
    localparam int LUT_SEQ_MAX = 4;
    localparam int LUT_LEN_W   = $clog2(LUT_SEQ_MAX + 1);
    localparam int LUT_SEQ_W   = LUT_SEQ_MAX * LUT_KEY_W;

    typedef struct packed {
        logic                 hit;
        logic [LUT_LEN_W-1:0] len;
        logic [LUT_SEQ_W-1:0] seq;
    } combo_t;

    // Step k sits at seq[k*2 +: 2]; unused upper steps are zero.
    localparam combo_t CMB_ONE   = '{hit: 1'b1, len: 3'd2, seq: 8'h00};  // 0,0
    localparam combo_t CMB_TWO   = '{hit: 1'b1, len: 3'd2, seq: 8'h05};  // 1,1
    localparam combo_t CMB_THREE = '{hit: 1'b1, len: 3'd3, seq: 8'h04};  // 0,1,0
    localparam combo_t CMB_SEVEN = '{hit: 1'b1, len: 3'd3, seq: 8'h11};  // 1,0,1
    localparam combo_t CMB_NONE  = '{hit: 1'b0, len: 3'd0, seq: 8'h00};

    function automatic combo_t combo_lookup(input logic [6:0] sym);
        combo_t entry;
        case (sym)
            SYM_ONE:   entry = CMB_ONE;
            SYM_TWO:   entry = CMB_TWO;
            SYM_THREE: entry = CMB_THREE;
            SYM_SEVEN: entry = CMB_SEVEN;
            default:   entry = CMB_NONE;
        endcase
        return entry;
    endfunction

endpackage

// File: rtl/combo_lut.sv
// Combinational symbol-to-combo table; sits beside the controller and answers its lut_sym query.
module combo_lut
    import game_pkg::*;
(
    input  logic [6:0]           sym,
    output logic                 hit,
    output logic [LUT_LEN_W-1:0] len,
    output logic [LUT_SEQ_W-1:0] seq
);

    combo_t entry;

    always_comb begin
        entry = combo_lookup(sym);
        hit   = entry.hit;
        len   = entry.len;
        seq   = entry.seq;
    end

endmodule

// File: rtl/combo_game_ctrl.sv
// Timed combo game controller: fetches a symbol, matches the player's button combo against it,
// scores completed combos and updates the player's high score when the round timer runs out.
module combo_game_ctrl
    import game_pkg::*;
#(
    parameter int N_BTN    = 3,
    parameter int KEY_W    = 2,
    parameter int SEQ_MAX  = 4,
    parameter int SYM_W    = 7,
    parameter int PID_W    = 2,
    parameter int SCORE_W  = 4,
    parameter int ROUND_T1 = 3,
    parameter int ROUND_T0 = 0,
    parameter int STRICT   = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [N_BTN-1:0]                btn,
    input  logic [PID_W-1:0]                player_id,
    input  logic [SYM_W-1:0]                symbol,
    output logic                            sym_change,
    output logic [SYM_W-1:0]                disp_symbol,
    output logic [SYM_W-1:0]                lut_sym,
    input  logic                            lut_hit,
    input  logic [$clog2(SEQ_MAX+1)-1:0]    lut_len,
    input  logic [SEQ_MAX*KEY_W-1:0]        lut_seq,
    output logic                            tick_en,
    output logic                            time_load,
    output logic [3:0]                      time_t1,
    output logic [3:0]                      time_t0,
    input  logic [3:0]                      rem_t1,
    input  logic [3:0]                      rem_t0,
    output logic [PID_W-1:0]                ram_addr,
    output logic [SCORE_W-1:0]              ram_wdata,
    output logic                            ram_wren,
    input  logic [SCORE_W-1:0]              ram_q,
    output logic [SCORE_W-1:0]              score,
    output logic [SCORE_W-1:0]              misses,
    output logic [SCORE_W-1:0]              best_score,
    output logic                            game_over
);

    localparam int                 LEN_W     = $clog2(SEQ_MAX + 1);
    localparam logic [KEY_W-1:0]   CONFIRM   = KEY_W'(N_BTN - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_t                   state_reg;
    logic [LEN_W-1:0]         step_reg;
    logic [LEN_W-1:0]         len_reg;
    logic [SEQ_MAX*KEY_W-1:0] seq_reg;
    logic                     armed_reg;
    logic [N_BTN-1:0]         prev_btn_reg;
    logic [SYM_W-1:0]         prev_sym_reg;
    logic                     press_vld_reg;
    logic [KEY_W-1:0]         press_key_reg;

    logic [N_BTN-1:0]         rise;
    logic                     rise_onehot;
    logic [KEY_W-1:0]         rise_key;
    logic [KEY_W-1:0]         seq_key [SEQ_MAX];
    logic [KEY_W-1:0]         exp_key;
    logic                     rem_nonzero;
    logic                     timeout;
    logic                     in_round;
    logic                     step_hit;
    logic                     confirm_hit;

    for (genvar gi = 0; gi < SEQ_MAX; gi++) begin : g_seq_key
        assign seq_key[gi] = seq_reg[gi*KEY_W +: KEY_W];
    end

    // A press is a single fresh rising edge; chords and held buttons produce nothing.
    assign rise        = btn & ~prev_btn_reg;
    assign rise_onehot = (rise != '0) && ((rise & (rise - 1'b1)) == '0);

    always_comb begin
        rise_key = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (rise[i]) rise_key = KEY_W'(i);
        end
    end

    always_comb begin
        exp_key = '0;
        for (int k = 0; k < SEQ_MAX; k++) begin
            if (step_reg == LEN_W'(k)) exp_key = seq_key[k];
        end
    end

    assign rem_nonzero = ({rem_t1, rem_t0} != 8'd0);
    assign timeout     = armed_reg && !rem_nonzero;
    assign in_round    = (state_reg == LOAD) || (state_reg == FETCH) ||
                         (state_reg == MATCH) || (state_reg == SCORE);
    assign step_hit    = (step_reg < len_reg) && (press_key_reg == exp_key) &&
                         (press_key_reg != CONFIRM);
    assign confirm_hit = (step_reg >= len_reg) && (press_key_reg == CONFIRM);

    // The write decision needs ram_q, which only becomes valid in CMP, so it is decoded here.
    assign ram_wren  = (state_reg == CMP) && (score > ram_q) && !rst;
    assign ram_wdata = (state_reg == CMP) ? score : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            step_reg      <= '0;
            len_reg       <= '0;
            seq_reg       <= '0;
            armed_reg     <= 1'b0;
            prev_btn_reg  <= '0;
            prev_sym_reg  <= '1;
            press_vld_reg <= 1'b0;
            press_key_reg <= '0;
            sym_change    <= 1'b0;
            disp_symbol   <= '1;
            lut_sym       <= '0;
            tick_en       <= 1'b0;
            time_load     <= 1'b0;
            time_t1       <= '0;
            time_t0       <= '0;
            ram_addr      <= '0;
            score         <= '0;
            misses        <= '0;
            best_score    <= '0;
            game_over     <= 1'b0;
        end else begin
            prev_btn_reg  <= btn;
            press_vld_reg <= rise_onehot;
            press_key_reg <= rise_key;
            time_load     <= 1'b0;
            sym_change    <= 1'b0;
            if (tick_en && rem_nonzero) armed_reg <= 1'b1;

            if (timeout && in_round) begin
                state_reg <= RD;
                tick_en   <= 1'b0;
                ram_addr  <= player_id;
            end else begin
                case (state_reg)
                    IDLE, DONE: begin
                        if (start) begin
                            state_reg <= LOAD;
                            time_load <= 1'b1;
                            time_t1   <= 4'(ROUND_T1);
                            time_t0   <= 4'(ROUND_T0);
                            tick_en   <= 1'b1;
                            score     <= '0;
                            misses    <= '0;
                            armed_reg <= 1'b0;
                            game_over <= 1'b0;
                        end
                    end
                    LOAD: state_reg <= FETCH;
                    FETCH: begin
                        lut_sym     <= symbol;
                        disp_symbol <= symbol;
                        // Alternate the request so the symbol source sees distinct pulses.
                        if (symbol == prev_sym_reg || (lut_sym == symbol && !lut_hit)) begin
                            sym_change <= ~sym_change;
                        end else if (lut_sym == symbol) begin
                            len_reg      <= lut_len;
                            seq_reg      <= lut_seq;
                            prev_sym_reg <= symbol;
                            step_reg     <= '0;
                            state_reg    <= MATCH;
                        end
                    end
                    MATCH: begin
                        if (press_vld_reg) begin
                            if (step_hit) begin
                                step_reg <= step_reg + 1'b1;
                            end else if (confirm_hit) begin
                                state_reg  <= SCORE;
                                sym_change <= 1'b1;
                                if (score != SCORE_MAX) score <= score + 1'b1;
                            end else if (STRICT != 0) begin
                                step_reg <= '0;
                                if (misses != SCORE_MAX) misses <= misses + 1'b1;
                            end
                        end
                    end
                    SCORE: state_reg <= FETCH;
                    RD:    state_reg <= CMP;
                    CMP: begin
                        best_score <= (score > ram_q) ? score : ram_q;
                        game_over  <= 1'b1;
                        state_reg  <= DONE;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_combo_game_ctrl.sv
// Bench for combo_game_ctrl with the combo table, a BCD countdown timer and a score RAM modelled around it.
module tb_combo_game_ctrl;
    import game_pkg::*;

    localparam int DIV = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] btn = '0;
    logic [1:0] player_id = '0;
    logic [6:0] symbol = SYM_ONE;
    logic       sym_change, tick_en, time_load, ram_wren, game_over;
    logic [6:0] disp_symbol, lut_sym;
    logic       lut_hit;
    logic [2:0] lut_len;
    logic [7:0] lut_seq;
    logic [3:0] time_t1, time_t0;
    logic [3:0] rem_t1, rem_t0;
    logic [1:0] ram_addr;
    logic [3:0] ram_wdata, ram_q, score, misses, best_score;

    logic [3:0] score_ram [4] = '{default: 4'd0};
    logic       preload_en = 1'b0;
    logic [1:0] preload_addr = '0;
    logic [3:0] preload_val = '0;
    bit         freeze = 1'b1;
    int         div_cnt;

    int         n_checks = 0;
    int         n_fail = 0;
    int         wr_count = 0;
    int         sc_count = 0;
    logic [3:0] last_score = '0;
    logic [3:0] last_miss = '0;
    logic [3:0] exp_score_q [$];
    logic [3:0] exp_miss_q [$];
    logic [3:0] exp_wr_q [$];
    logic [6:0] sym_q [$];

    always #5 clk = ~clk;

    combo_game_ctrl #(
        .N_BTN(3), .KEY_W(2), .SEQ_MAX(4), .SYM_W(7), .PID_W(2), .SCORE_W(4),
        .ROUND_T1(3), .ROUND_T0(0), .STRICT(1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .btn(btn), .player_id(player_id),
        .symbol(symbol), .sym_change(sym_change), .disp_symbol(disp_symbol),
        .lut_sym(lut_sym), .lut_hit(lut_hit), .lut_len(lut_len), .lut_seq(lut_seq),
        .tick_en(tick_en), .time_load(time_load), .time_t1(time_t1), .time_t0(time_t0),
        .rem_t1(rem_t1), .rem_t0(rem_t0), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_wren(ram_wren), .ram_q(ram_q), .score(score), .misses(misses),
        .best_score(best_score), .game_over(game_over)
    );

    combo_lut u_lut (.sym(lut_sym), .hit(lut_hit), .len(lut_len), .seq(lut_seq));

    // BCD countdown timer, one step every DIV enabled cycles unless frozen by the bench.
    always @(posedge clk) begin
        if (rst) begin
            rem_t1 <= 4'd0; rem_t0 <= 4'd0; div_cnt <= 0;
        end else if (time_load) begin
            rem_t1 <= time_t1; rem_t0 <= time_t0; div_cnt <= 0;
        end else if (tick_en && !freeze && (rem_t1 != 4'd0 || rem_t0 != 4'd0)) begin
            if (div_cnt == DIV - 1) begin
                div_cnt <= 0;
                if (rem_t0 == 4'd0) begin rem_t1 <= rem_t1 - 4'd1; rem_t0 <= 4'd9; end
                else rem_t0 <= rem_t0 - 4'd1;
            end else begin
                div_cnt <= div_cnt + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (preload_en) score_ram[preload_addr] <= preload_val;
        else if (ram_wren) score_ram[ram_addr] <= ram_wdata;
        ram_q <= score_ram[ram_addr];
    end

    // Symbol source: advance to the next queued symbol on each change request.
    always @(negedge clk) begin
        if (sym_change && sym_q.size() != 0) symbol = sym_q.pop_front();
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Scoreboard monitor: score/miss increments and RAM writes are popped against queued expectations.
    always @(negedge clk) begin
        if (rst) begin
            last_score = '0;
            last_miss  = '0;
        end else begin
            if (sym_change) sc_count++;
            if (score != last_score && score != 4'd0) begin
                if (exp_score_q.size() == 0) check("score_unexpected", 32'(score), 32'(last_score));
                else check("score_step", 32'(score), 32'(exp_score_q.pop_front()));
            end
            if (misses != last_miss && misses != 4'd0) begin
                if (exp_miss_q.size() == 0) check("miss_unexpected", 32'(misses), 32'(last_miss));
                else check("miss_step", 32'(misses), 32'(exp_miss_q.pop_front()));
            end
            if (ram_wren) begin
                wr_count++;
                if (exp_wr_q.size() == 0) check("wr_unexpected", 32'(ram_wdata), 32'hFFFF);
                else check("ram_wdata", 32'(ram_wdata), 32'(exp_wr_q.pop_front()));
            end
            last_score = score;
            last_miss  = misses;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int k);
        btn[k] = 1'b1;
        cyc(2);
        btn = '0;
        cyc(3);
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic wait_load();
        bit seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (time_load) seen = 1'b1;
        end
        check("time_load_seen", 32'(seen), 1);
        check("time_t1", 32'(time_t1), 3);
        check("time_t0", 32'(time_t0), 0);
        cyc(1);
    endtask

    task automatic wait_over();
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (game_over) seen = 1'b1;
        end
        check("game_over_seen", 32'(seen), 1);
        cyc(1);
    endtask

    task automatic preload(input logic [1:0] a, input logic [3:0] v);
        preload_addr = a;
        preload_val  = v;
        preload_en   = 1'b1;
        cyc(1);
        preload_en   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pc;
        cyc(3);
        @(negedge clk);
        check("rst_disp_symbol", 32'(disp_symbol), 32'h7F);
        check("rst_score", 32'(score), 0);
        check("rst_misses", 32'(misses), 0);
        check("rst_tick_en", 32'(tick_en), 0);
        check("rst_game_over", 32'(game_over), 0);
        check("rst_sym_change", 32'(sym_change), 0);
        check("rst_ram_wren", 32'(ram_wren), 0);
        cyc(1);
        rst = 1'b0;

        // Round 1: symbol 3F combo {0,0}, then 07 combo {1,0,1}, then 3F, then 3E.
        sym_q.push_back(SYM_SEVEN);
        sym_q.push_back(SYM_ONE);
        sym_q.push_back(SYM_TWO);
        do_start();
        wait_load();
        cyc(4);
        check("disp_symbol_3f", 32'(disp_symbol), 32'h3F);
        press(0); press(0);
        exp_score_q.push_back(4'd1);
        press(2);
        check("score_after_3f", 32'(score), 1);
        check("sym_change_pulsed", 32'(sc_count > 0), 1);

        cyc(3);
        check("disp_symbol_07", 32'(disp_symbol), 32'h07);
        press(1);
        exp_miss_q.push_back(4'd1);
        press(2);
        check("misses_after_wrong", 32'(misses), 1);
        press(1); press(0); press(1);
        exp_score_q.push_back(4'd2);
        press(2);
        check("score_after_07", 32'(score), 2);

        // Chord and held-button handling on symbol 3F.
        cyc(3);
        btn = 3'b011;
        cyc(2);
        btn = '0;
        cyc(3);
        exp_miss_q.push_back(4'd2);
        press(2);
        btn[0] = 1'b1;
        cyc(5);
        btn = '0;
        cyc(3);
        exp_miss_q.push_back(4'd3);
        press(2);
        check("misses_after_hold", 32'(misses), 3);
        press(0); press(0);
        exp_score_q.push_back(4'd3);
        press(2);
        check("score_after_chord", 32'(score), 3);

        // Symbol 3E scored, then repeated: must keep requesting and never enter MATCH.
        cyc(3);
        press(1); press(1);
        exp_score_q.push_back(4'd4);
        press(2);
        pc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (sym_change) pc++;
        end
        check("repeat_sym_pulses", 32'(pc >= 3), 1);
        cyc(1);
        press(1); press(1); press(2);
        check("score_repeat_hold", 32'(score), 4);
        check("misses_repeat_hold", 32'(misses), 3);
        sym_q.push_back(SYM_SEVEN);
        cyc(4);
        press(1); press(0); press(1);
        exp_score_q.push_back(4'd5);
        press(2);
        check("score_before_timeout", 32'(score), 5);

        // Timeout with a lower stored high score: one write of 5.
        preload(2'd1, 4'd3);
        player_id = 2'd1;
        exp_wr_q.push_back(4'd5);
        freeze = 1'b0;
        wait_over();
        check("best_score_new", 32'(best_score), 5);
        check("wr_count_1", 32'(wr_count), 1);
        check("ram_mem1", 32'(score_ram[1]), 5);
        check("tick_en_done", 32'(tick_en), 0);

        // Restart from DONE with a higher stored score: no write.
        preload(2'd2, 4'd9);
        player_id = 2'd2;
        freeze = 1'b1;
        do_start();
        wait_load();
        check("score_cleared", 32'(score), 0);
        check("game_over_cleared", 32'(game_over), 0);
        freeze = 1'b0;
        wait_over();
        check("best_score_kept", 32'(best_score), 9);
        check("wr_count_still_1", 32'(wr_count), 1);

        // Reset in the middle of a round.
        sym_q.push_back(SYM_ONE);
        freeze = 1'b1;
        do_start();
        wait_load();
        cyc(6);
        press(0);
        rst = 1'b1;
        cyc(1);
        check("midrst_best_score", 32'(best_score), 0);
        check("midrst_disp_symbol", 32'(disp_symbol), 32'h7F);
        check("midrst_tick_en", 32'(tick_en), 0);
        check("midrst_lut_sym", 32'(lut_sym), 0);
        check("midrst_ram_wren", 32'(ram_wren), 0);
        rst = 1'b0;
        cyc(1);
        do_start();
        wait_load();

        check("score_q_drained", 32'(exp_score_q.size()), 0);
        check("miss_q_drained", 32'(exp_miss_q.size()), 0);
        check("wr_q_drained", 32'(exp_wr_q.size()), 0);
        check("wr_count_final", 32'(wr_count), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
